// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: assembles strobed serial bits into WIDTH-bit words
// with a valid/ready output and sticky overrun. Define SIPO_RX_PARITY_EN for a trailing even-parity bit.
module sipo_rx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sin,
    input  logic             i_sin_valid,
    input  logic             i_sof,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_dout_valid,
    input  logic             i_dout_ready,
    output logic             o_busy,
    output logic             o_overrun,
    output logic             o_parity_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LP_CNT_LAST = CW'(WIDTH);

    // state | meaning
    // IDLE  | no partial word held
    // SHIFT | 1..WIDTH-1 data bits held
    // PAR   | all data bits held, waiting for the parity bit
`ifdef SIPO_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]  r_shift, w_shift_nxt;
    logic [WIDTH-1:0]  r_dout, w_dout_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_ovr, w_ovr_nxt;
    logic              r_perr, w_perr_nxt;

    logic              w_fresh;
    logic [WIDTH-1:0]  w_base;
    logic [WIDTH-1:0]  w_ins;
    logic [CW-1:0]     w_cnt_inc;
    logic              w_load;
    logic [WIDTH-1:0]  w_load_word;
    logic              w_load_perr;

    // A start-of-frame bit, or any bit in IDLE, begins a word from an empty register.
    assign w_fresh   = (r_state == IDLE) || i_sof;
    assign w_base    = w_fresh ? '0 : r_shift;
    assign w_ins     = MSB_FIRST ? {w_base[WIDTH-2:0], i_sin} : {i_sin, w_base[WIDTH-1:1]};
    assign w_cnt_inc = w_fresh ? CW'(1) : r_cnt + CW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_dout_nxt  = r_dout;
        w_valid_nxt = r_valid;
        w_ovr_nxt   = r_ovr;
        w_perr_nxt  = r_perr;
        w_load      = 1'b0;
        w_load_word = '0;
        w_load_perr = 1'b0;

        if (i_clr) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_ovr_nxt   = 1'b0;
            w_perr_nxt  = 1'b0;
        end else begin
            if (i_sin_valid) begin
`ifdef SIPO_RX_PARITY_EN
                if (r_state == PAR && !i_sof) begin
                    w_load      = 1'b1;
                    w_load_word = r_shift;
                    w_load_perr = ^{r_shift, i_sin};
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_shift_nxt = w_ins;
                    if (w_cnt_inc == LP_CNT_LAST) begin
                        w_state_nxt = PAR;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = SHIFT;
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
`else
                w_shift_nxt = w_ins;
                if (w_cnt_inc == LP_CNT_LAST) begin
                    w_load      = 1'b1;
                    w_load_word = w_ins;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = SHIFT;
                    w_cnt_nxt   = w_cnt_inc;
                end
`endif
            end

            // A completing word may replace one being accepted on the same edge.
            if (w_load) begin
                if (!r_valid || i_dout_ready) begin
                    w_dout_nxt  = w_load_word;
                    w_valid_nxt = 1'b1;
                    w_perr_nxt  = w_load_perr;
                end else begin
                    w_ovr_nxt = 1'b1;
                end
            end else if (r_valid && i_dout_ready) begin
                w_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_dout  <= w_dout_nxt;
            r_valid <= w_valid_nxt;
            r_ovr   <= w_ovr_nxt;
            r_perr  <= w_perr_nxt;
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_valid = r_valid;
    assign o_busy       = (r_state != IDLE);
    assign o_overrun    = r_ovr;
    assign o_parity_err = r_perr;

endmodule
